mole_target_controller: RTL and testbench

Consumes the free-running `random_pos` from `random_generator` and runs one whack-a-mole round loop. Each turn it maps the random value onto a valid LED index, avoids repeating the previous target, lights that LED for a bounded window and scores a hit or a miss from the player switches. Sits between `random_generator` and the LED/score display logic.

---
 rtl/game_pkg.sv | 23 ++
 rtl/rise_detect.sv | 25 ++
 rtl/mole_target_controller.sv | 155 +++++++++++++++
 tb/tb_mole_target_controller.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game blocks: FSM states, the
// random position width and the default target count, so that
// random_generator and mole_target_controller agree on them.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_SHOW,
    ST_GAP
  } state_e;

  localparam int POS_W           = 5;
  localparam int NUM_TARGETS_DEF = 18;

  // Bits needed to hold the larger of the two timer reload values (N-1).
  function automatic int timer_width(int on_cycles, int gap_cycles);
    int longest;
    longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector. The delayed copy is registered; the rise
// vector is combinational so the consumer can react on the same edge that
// captures the new input level.
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_d_q;

  // Delay the input by one clock; cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) r_d_q <= '0;
    else        r_d_q <= d;
  end

  assign rise = d & ~r_d_q;

endmodule

// File: rtl/mole_target_controller.sv
// Whack-a-mole round controller: picks a non-repeating target from the
// free-running random position, lights it for a bounded window and scores a
// hit on a rising switch edge or a miss on timeout. All outputs registered.
module mole_target_controller
  import game_pkg::*;
#(
  parameter int NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int ON_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int SCORE_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [POS_W-1:0]       random_pos,
  input  logic [NUM_TARGETS-1:0] hit_sw,
  output logic [NUM_TARGETS-1:0] target_leds,
  output logic [POS_W-1:0]       target_idx,
  output logic                   target_valid,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic                   busy
);

  localparam int TIMER_W = timer_width(ON_CYCLES, GAP_CYCLES);

  localparam logic [TIMER_W-1:0]     ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [POS_W-1:0]       LAST_IDX = POS_W'(NUM_TARGETS - 1);
  localparam logic [NUM_TARGETS-1:0] LED_LSB  = NUM_TARGETS'(1);

  state_e                 r_state;
  logic [TIMER_W-1:0]     r_timer;
  logic                   r_prev_valid;
  logic [POS_W-1:0]       r_target_idx;
  logic [NUM_TARGETS-1:0] r_target_leds;
  logic                   r_target_valid;
  logic                   r_hit_pulse;
  logic                   r_miss_pulse;
  logic [SCORE_W-1:0]     r_score;
  logic                   r_busy;

  logic [NUM_TARGETS-1:0] w_rise;
  logic                   w_hit;
  logic [POS_W-1:0]       w_mapped;
  logic [POS_W-1:0]       w_next_idx;

  rise_detect #(
    .WIDTH (NUM_TARGETS)
  ) u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (hit_sw),
    .rise  (w_rise)
  );

  // The LED vector is the one-hot of the current target while in SHOW, so
  // masking with it keeps only the rise on the lit target's switch.
  assign w_hit = |(w_rise & r_target_leds);

  // Fold the random position into range and step past a repeated target.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_mapped = random_pos;
    if (int'(random_pos) >= NUM_TARGETS) begin
      // A single subtraction suffices: NUM_TARGETS >= 16 and random_pos < 32.
      w_mapped = random_pos - POS_W'(NUM_TARGETS);
    end
    w_next_idx = w_mapped;
    if (r_prev_valid && (w_mapped == r_target_idx)) begin
      w_next_idx = (w_mapped == LAST_IDX) ? '0 : w_mapped + POS_W'(1);
    end
  end

  // Round FSM with timer, score counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_prev_valid   <= 1'b0;
      r_target_idx   <= '0;
      r_target_leds  <= '0;
      r_target_valid <= 1'b0;
      r_hit_pulse    <= 1'b0;
      r_miss_pulse   <= 1'b0;
      r_score        <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      if (stop) begin
        // Abort keeps score and last target so the display can show them.
        r_state        <= ST_IDLE;
        r_target_leds  <= '0;
        r_target_valid <= 1'b0;
        r_busy         <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_score      <= '0;
              r_prev_valid <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= ST_PICK;
            end
          end
          ST_PICK: begin
            r_target_idx   <= w_next_idx;
            r_prev_valid   <= 1'b1;
            r_timer        <= ON_LOAD;
            r_target_leds  <= LED_LSB << w_next_idx;
            r_target_valid <= 1'b1;
            r_state        <= ST_SHOW;
          end
          ST_SHOW: begin
            // A hit is checked before the timeout so a last-cycle hit wins.
            if (w_hit) begin
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
              r_hit_pulse    <= 1'b1;
              r_target_leds  <= '0;
              r_target_valid <= 1'b0;
              r_timer        <= GAP_LOAD;
              r_state        <= ST_GAP;
            end else if (r_timer == '0) begin
              r_miss_pulse   <= 1'b1;
              r_target_leds  <= '0;
              r_target_valid <= 1'b0;
              r_timer        <= GAP_LOAD;
              r_state        <= ST_GAP;
            end else begin
              r_timer <= r_timer - TIMER_W'(1);
            end
          end
          ST_GAP: begin
            if (r_timer == '0) r_state <= ST_PICK;
            else               r_timer <= r_timer - TIMER_W'(1);
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign target_leds  = r_target_leds;
  assign target_idx   = r_target_idx;
  assign target_valid = r_target_valid;
  assign hit_pulse    = r_hit_pulse;
  assign miss_pulse   = r_miss_pulse;
  assign score        = r_score;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mole_target_controller.sv
// Self-checking bench for mole_target_controller with NUM_TARGETS=18,
// ON_CYCLES=8, GAP_CYCLES=4. Inputs are driven 1 ns after each rising edge
// and outputs sampled at the same point, i.e. away from the active edge.
module tb_mole_target_controller;

  localparam int NT   = 18;
  localparam int ONC  = 8;
  localparam int GAPC = 4;
  localparam int SW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [4:0]    random_pos;
  logic [NT-1:0] hit_sw;
  logic [NT-1:0] target_leds;
  logic [4:0]    target_idx;
  logic          target_valid;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [SW-1:0] score;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mole_target_controller #(
    .NUM_TARGETS (NT),
    .ON_CYCLES   (ONC),
    .GAP_CYCLES  (GAPC),
    .SCORE_W     (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .random_pos   (random_pos),
    .hit_sw       (hit_sw),
    .target_leds  (target_leds),
    .target_idx   (target_idx),
    .target_valid (target_valid),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .score        (score),
    .busy         (busy)
  );

  // ---------------- reference model (game rules, not hardware) ----------
  function automatic int model_target(int rp, int prev, bit prev_ok);
    int m;
    m = rp % NT;
    if (prev_ok && (m == prev)) m = (m + 1) % NT;
    return m;
  endfunction

  function automatic logic [NT-1:0] onehot(int i);
    logic [NT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int sat_inc(int s);
    return (s >= 255) ? 255 : s + 1;
  endfunction

  // ---------------- helpers ---------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    hit_sw     = '0;
    random_pos = '0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  // Leaves the sample point in the PICK cycle.
  task automatic start_game(input int rp);
    random_pos = 5'(rp);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_lit(output int dark, input int budget);
    dark = 0;
    while (target_valid !== 1'b1 && dark < budget) begin
      tick();
      dark++;
    end
    n_vec++;
    if (target_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wait_lit timeout: target_valid=%b after %0d cycles, required 1", target_valid, dark);
    end
  endtask

  // ---------------- tests -----------------------------------------------
  task automatic test_reset();
    apply_reset(3);
    tick();
    n_vec++;
    if ({target_leds, target_idx, target_valid, hit_pulse, miss_pulse, score} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: leds=%h idx=%0d valid=%b hit=%b miss=%b score=%0d, required all 0",
               target_leds, target_idx, target_valid, hit_pulse, miss_pulse, score);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
  endtask

  // Start with random_pos=20, then hit in the 3rd SHOW cycle.
  task automatic test_start_and_hit();
    int exp_idx;
    int exp_next;
    apply_reset(2);
    start_game(20);
    n_vec++;
    if (busy !== 1'b1 || target_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pick_cycle: busy=%b valid=%b, required busy=1 valid=0", busy, target_valid);
    end
    tick();
    exp_idx = model_target(20, 0, 1'b0);
    n_vec++;
    if (target_idx !== 5'(exp_idx) || target_leds !== onehot(exp_idx) || target_valid !== 1'b1) begin
      n_err++;
      $display("FAIL start_target: idx=%0d leds=%h valid=%b, required idx=%0d leds=%h valid=1",
               target_idx, target_leds, target_valid, exp_idx, onehot(exp_idx));
    end
    random_pos = 5'd9;
    exp_next   = model_target(9, exp_idx, 1'b1);
    tick();
    tick();
    hit_sw = onehot(exp_idx);
    tick();
    hit_sw = '0;
    n_vec++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || target_leds !== '0) begin
      n_err++;
      $display("FAIL hit_3rd_cycle: hit=%b miss=%b score=%0d leds=%h, required hit=1 miss=0 score=1 leds=0",
               hit_pulse, miss_pulse, score, target_leds);
    end
    for (int i = 1; i < GAPC; i++) begin
      tick();
      n_vec++;
      if (hit_pulse !== 1'b0 || target_leds !== '0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL gap_after_hit[%0d]: hit=%b leds=%h busy=%b, required 0/0/1", i, hit_pulse, target_leds, busy);
      end
    end
    tick();
    n_vec++;
    if (target_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pick_after_gap: valid=%b required 0", target_valid);
    end
    tick();
    n_vec++;
    if (target_valid !== 1'b1 || target_idx !== 5'(exp_next)) begin
      n_err++;
      $display("FAIL second_turn: valid=%b idx=%0d, required valid=1 idx=%0d", target_valid, target_idx, exp_next);
    end
  endtask

  // No rise (switch already high before SHOW) -> lit exactly ONC cycles, miss.
  task automatic test_miss();
    int lit;
    int dark;
    apply_reset(2);
    hit_sw = onehot(2);
    start_game(2);
    tick();
    lit = 0;
    while (target_valid === 1'b1 && lit < 20) begin
      lit++;
      tick();
    end
    n_vec++;
    if (lit !== ONC) begin
      n_err++;
      $display("FAIL lit_length: got %0d cycles required %0d", lit, ONC);
    end
    n_vec++;
    if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 8'd0) begin
      n_err++;
      $display("FAIL miss_pulse: miss=%b hit=%b score=%0d, required miss=1 hit=0 score=0", miss_pulse, hit_pulse, score);
    end
    tick();
    n_vec++;
    if (miss_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL miss_width: miss=%b on 2nd gap cycle, required 0", miss_pulse);
    end
    // From the 2nd GAP cycle: GAPC-1 more GAP cycles plus one PICK cycle.
    wait_lit(dark, 20);
    n_vec++;
    if (dark !== GAPC) begin
      n_err++;
      $display("FAIL gap_length: got %0d required %0d", dark, GAPC);
    end
    hit_sw = '0;
  endtask

  task automatic test_repeat_wrap();
    int rps[4];
    int prev;
    int exp_idx;
    int dark;
    rps = '{2, 17, 17, 31};
    apply_reset(2);
    start_game(2);
    tick();
    prev = model_target(2, 0, 1'b0);
    foreach (rps[k]) begin
      hit_sw     = onehot(prev);
      random_pos = 5'(rps[k]);
      tick();
      hit_sw = '0;
      wait_lit(dark, 20);
      exp_idx = model_target(rps[k], prev, 1'b1);
      n_vec++;
      if (target_idx !== 5'(exp_idx) || target_leds !== onehot(exp_idx)) begin
        n_err++;
        $display("FAIL repeat_wrap[%0d] rp=%0d prev=%0d: idx=%0d required %0d", k, rps[k], prev, target_idx, exp_idx);
      end
      prev = exp_idx;
    end
  endtask

  task automatic test_other_switch();
    apply_reset(2);
    start_game(2);
    tick();
    hit_sw = onehot(5);
    tick();
    hit_sw = '0;
    n_vec++;
    if (hit_pulse !== 1'b0 || target_valid !== 1'b1 || score !== 8'd0) begin
      n_err++;
      $display("FAIL other_switch: hit=%b valid=%b score=%0d, required 0/1/0", hit_pulse, target_valid, score);
    end
  endtask

  task automatic test_final_cycle_hit();
    apply_reset(2);
    start_game(6);
    tick();
    repeat (ONC - 1) tick();
    n_vec++;
    if (target_valid !== 1'b1) begin
      n_err++;
      $display("FAIL final_cycle_lit: valid=%b required 1", target_valid);
    end
    hit_sw = onehot(6);
    tick();
    hit_sw = '0;
    n_vec++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1) begin
      n_err++;
      $display("FAIL final_cycle_hit: hit=%b miss=%b score=%0d, required 1/0/1", hit_pulse, miss_pulse, score);
    end
    tick();
    n_vec++;
    if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL final_cycle_after: hit=%b miss=%b, required 0/0", hit_pulse, miss_pulse);
    end
  endtask

  task automatic test_stop_start();
    int dark;
    int exp_idx;
    apply_reset(2);
    start_game(4);
    tick();
    hit_sw     = onehot(4);
    random_pos = 5'd7;
    tick();
    hit_sw = '0;
    wait_lit(dark, 20);
    exp_idx = model_target(7, 4, 1'b1);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || target_valid !== 1'b0 || target_leds !== '0 || score !== 8'd1 ||
        target_idx !== 5'(exp_idx) || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL stop_start: busy=%b valid=%b leds=%h score=%0d idx=%0d, required 0/0/0/1/%0d",
               busy, target_valid, target_leds, score, target_idx, exp_idx);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_stays_idle: busy=%b required 0", busy);
    end
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || score !== 8'd1) begin
      n_err++;
      $display("FAIL stop_start_idle: busy=%b score=%0d, required 0/1", busy, score);
    end
  endtask

  task automatic test_reset_mid_show();
    apply_reset(2);
    start_game(10);
    tick();
    hit_sw = onehot(10);
    tick();
    hit_sw = '0;
    repeat (GAPC + 2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({target_leds, target_idx, target_valid, hit_pulse, miss_pulse, score, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_show: leds=%h idx=%0d valid=%b score=%0d busy=%b, required all 0",
               target_leds, target_idx, target_valid, score, busy);
    end
  endtask

  // Hit every target immediately until the score has saturated.
  task automatic test_saturate();
    int exp_score;
    int prev;
    int rp;
    int exp_idx;
    int dark;
    apply_reset(2);
    start_game(0);
    tick();
    prev      = model_target(0, 0, 1'b0);
    exp_score = 0;
    for (int k = 0; k < 260; k++) begin
      rp         = int'($urandom_range(0, 31));
      hit_sw     = onehot(prev);
      random_pos = 5'(rp);
      tick();
      hit_sw    = '0;
      exp_score = sat_inc(exp_score);
      n_vec++;
      if (hit_pulse !== 1'b1 || score !== 8'(exp_score)) begin
        n_err++;
        $display("FAIL saturate[%0d]: hit=%b score=%0d, required hit=1 score=%0d", k, hit_pulse, score, exp_score);
      end
      wait_lit(dark, 20);
      exp_idx = model_target(rp, prev, 1'b1);
      n_vec++;
      if (target_idx !== 5'(exp_idx)) begin
        n_err++;
        $display("FAIL saturate_idx[%0d]: idx=%0d required %0d", k, target_idx, exp_idx);
      end
      prev = exp_idx;
    end
  endtask

  // Random turns: random positions, random hit time (or none), switch noise.
  task automatic test_random();
    int prev;
    int rp;
    int exp_idx;
    int exp_score;
    int hit_at;
    int dark;
    logic [NT-1:0] noise;
    apply_reset(2);
    rp = int'($urandom_range(0, 31));
    start_game(rp);
    wait_lit(dark, 20);
    exp_idx   = model_target(rp, 0, 1'b0);
    exp_score = 0;
    for (int t = 0; t < 60; t++) begin
      n_vec++;
      if (target_idx !== 5'(exp_idx) || target_leds !== onehot(exp_idx)) begin
        n_err++;
        $display("FAIL rand_target[%0d] rp=%0d: idx=%0d leds=%h, required idx=%0d", t, rp, target_idx, target_leds, exp_idx);
      end
      prev       = exp_idx;
      rp         = int'($urandom_range(0, 31));
      random_pos = 5'(rp);
      hit_at     = int'($urandom_range(1, ONC + 3));
      for (int c = 1; c <= ONC; c++) begin
        noise  = NT'($urandom()) & ~onehot(prev);
        hit_sw = (c == hit_at) ? (noise | onehot(prev)) : noise;
        tick();
        if (c == hit_at) begin
          exp_score = sat_inc(exp_score);
          n_vec++;
          if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'(exp_score) || target_leds !== '0) begin
            n_err++;
            $display("FAIL rand_hit[%0d] c=%0d: hit=%b miss=%b score=%0d leds=%h, required 1/0/%0d/0",
                     t, c, hit_pulse, miss_pulse, score, target_leds, exp_score);
          end
          break;
        end else if (c == ONC) begin
          n_vec++;
          if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 8'(exp_score) || target_leds !== '0) begin
            n_err++;
            $display("FAIL rand_miss[%0d]: miss=%b hit=%b score=%0d leds=%h, required 1/0/%0d/0",
                     t, miss_pulse, hit_pulse, score, target_leds, exp_score);
          end
        end else begin
          n_vec++;
          if (target_valid !== 1'b1 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL rand_show[%0d] c=%0d: valid=%b hit=%b miss=%b, required 1/0/0",
                     t, c, target_valid, hit_pulse, miss_pulse);
          end
        end
      end
      hit_sw = '0;
      // From the first GAP cycle: GAPC GAP cycles plus one PICK cycle.
      wait_lit(dark, 20);
      n_vec++;
      if (dark !== GAPC + 1) begin
        n_err++;
        $display("FAIL rand_gap[%0d]: dark=%0d required %0d", t, dark, GAPC + 1);
      end
      exp_idx = model_target(rp, prev, 1'b1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    hit_sw     = '0;
    random_pos = '0;
    test_reset();
    test_start_and_hit();
    test_miss();
    test_repeat_wrap();
    test_other_switch();
    test_final_cycle_hit();
    test_stop_start();
    test_reset_mid_show();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
